// File: rtl/usec_stamp_pkg.sv
// rtl/usec_stamp_pkg.sv - shared constants and FSM state types for the event stamper
package usec_stamp_pkg;

    localparam logic [3:0] REG_STATUS = 4'h0;
    localparam logic [3:0] REG_TS_HI  = 4'h4;
    localparam logic [3:0] REG_TS_LO  = 4'h8;
    localparam logic [3:0] REG_MASK   = 4'hC;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] ERR_PATTERN = 32'h0DEC0DE0;

    localparam int CTRL_CLEAR_BIT  = 0;
    localparam int CTRL_ENABLE_BIT = 1;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2
    } rd_state_t;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

endpackage

// File: rtl/stamp_fifo.sv
// rtl/stamp_fifo.sv - synchronous first-word-fall-through record FIFO
// Ports: clk, resetn (sync, active-low); push/wr_data enqueue; pop dequeues head;
//        clear empties; full, empty, count (log2(DEPTH)+1 bits), head (current oldest record).
module stamp_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign head  = mem[rd_ptr];

    // Fullness is judged on the pre-pop count, so a push into a full FIFO is
    // refused even when a pop happens in the same cycle. Clear wins over both.
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/usec_event_stamper.sv
// rtl/usec_event_stamper.sv - timestamps event edges into a FIFO drained over AXI4-Lite
// Ports: AXI_ACLK, AXI_ARESETN (sync, active-low); usec_counter (64-bit time);
//        event_in (EVENT_COUNT levels); S_AXI_* AXI4-Lite slave;
//        irq (only with USEC_STAMP_IRQ_EN defined).
module usec_event_stamper
    import usec_stamp_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 4,
    parameter int EVENT_COUNT    = 4,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                        AXI_ACLK,
    input  logic                        AXI_ARESETN,
    input  logic [63:0]                 usec_counter,
    input  logic [EVENT_COUNT-1:0]      event_in,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                  S_AXI_AWPROT,
    input  logic                        S_AXI_AWVALID,
    output logic                        S_AXI_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                        S_AXI_WVALID,
    output logic                        S_AXI_WREADY,
    output logic [1:0]                  S_AXI_BRESP,
    output logic                        S_AXI_BVALID,
    input  logic                        S_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                  S_AXI_ARPROT,
    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                  S_AXI_RRESP,
    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY
`ifdef USEC_STAMP_IRQ_EN
    ,
    output logic                        irq
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = EVENT_COUNT + 64;

    // Capture path
    logic [EVENT_COUNT-1:0] prev_q;
    logic [EVENT_COUNT-1:0] edge_vec;
    logic                   enable_q;
    logic                   overflow_q;
    logic                   push_req;
    logic                   clear_now;
    logic                   pop_req;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic [RW-1:0]          fifo_head;

    // Read side
    rd_state_t                 rd_state, rd_next;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_nxt;
    logic [1:0]                rresp_q, rresp_nxt;
    logic                      latch_en;
    logic [31:0]               lat_lo_q;
    logic [EVENT_COUNT-1:0]    lat_mask_q;

    // Write side
    wr_state_t                 wr_state, wr_next;
    logic                      aw_done_q, w_done_q;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, eff_addr;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, eff_data;
    logic                      aw_hs, w_hs, wr_apply, ctrl_hit;
    logic [1:0]                bresp_q;

    logic                      unused_inputs;

    assign edge_vec  = event_in & ~prev_q;
    assign push_req  = enable_q & (|edge_vec);

    stamp_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (AXI_ACLK),
        .resetn  (AXI_ARESETN),
        .push    (push_req),
        .pop     (pop_req),
        .clear   (clear_now),
        .wr_data ({edge_vec, usec_counter}),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .head    (fifo_head)
    );

    // ---------------- write channel ----------------
    assign aw_hs    = (wr_state == WR_IDLE) & ~aw_done_q & S_AXI_AWVALID;
    assign w_hs     = (wr_state == WR_IDLE) & ~w_done_q & S_AXI_WVALID;
    // Use the live bus value when the handshake completes this cycle.
    assign eff_addr = aw_hs ? S_AXI_AWADDR : awaddr_q;
    assign eff_data = w_hs ? S_AXI_WDATA : wdata_q;
    assign wr_apply = (wr_state == WR_IDLE) & (aw_done_q | aw_hs) & (w_done_q | w_hs);
    assign ctrl_hit = (eff_addr == AXI_ADDR_WIDTH'(REG_STATUS));
    assign clear_now = wr_apply & ctrl_hit & eff_data[CTRL_CLEAR_BIT];

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: if (wr_apply) wr_next = WR_RESP;
            WR_RESP: if (S_AXI_BREADY) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            wr_state  <= WR_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            bresp_q   <= RESP_OKAY;
            enable_q  <= 1'b0;
        end else begin
            wr_state <= wr_next;
            if (aw_hs) begin
                aw_done_q <= 1'b1;
                awaddr_q  <= S_AXI_AWADDR;
            end
            if (w_hs) begin
                w_done_q <= 1'b1;
                wdata_q  <= S_AXI_WDATA;
            end
            if (wr_apply) begin
                bresp_q <= ctrl_hit ? RESP_OKAY : RESP_SLVERR;
                if (ctrl_hit) begin
                    enable_q <= eff_data[CTRL_ENABLE_BIT];
                end
            end
            if ((wr_state == WR_RESP) && S_AXI_BREADY) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = (wr_state == WR_IDLE) & ~aw_done_q;
    assign S_AXI_WREADY  = (wr_state == WR_IDLE) & ~w_done_q;
    assign S_AXI_BVALID  = (wr_state == WR_RESP);
    assign S_AXI_BRESP   = bresp_q;

    // ---------------- read channel ----------------
    always_comb begin
        rd_next   = rd_state;
        rdata_nxt = rdata_q;
        rresp_nxt = rresp_q;
        pop_req   = 1'b0;
        latch_en  = 1'b0;
        case (rd_state)
            RD_IDLE: if (S_AXI_ARVALID) rd_next = RD_WAIT;
            RD_WAIT: begin
                rd_next   = RD_RESP;
                rresp_nxt = RESP_OKAY;
                case (araddr_q)
                    AXI_ADDR_WIDTH'(REG_STATUS):
                        rdata_nxt = {overflow_q, enable_q, 14'd0,
                                     {(16-CW){1'b0}}, fifo_count};
                    AXI_ADDR_WIDTH'(REG_TS_HI): begin
                        if (fifo_empty) begin
                            rdata_nxt = ERR_PATTERN;
                            rresp_nxt = RESP_SLVERR;
                        end else begin
                            rdata_nxt = fifo_head[63:32];
                            pop_req   = 1'b1;
                            latch_en  = 1'b1;
                        end
                    end
                    AXI_ADDR_WIDTH'(REG_TS_LO):
                        rdata_nxt = lat_lo_q;
                    AXI_ADDR_WIDTH'(REG_MASK):
                        rdata_nxt = {{(32-EVENT_COUNT){1'b0}}, lat_mask_q};
                    default: begin
                        rdata_nxt = ERR_PATTERN;
                        rresp_nxt = RESP_SLVERR;
                    end
                endcase
            end
            RD_RESP: if (S_AXI_RREADY) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            rd_state   <= RD_IDLE;
            araddr_q   <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            lat_lo_q   <= '0;
            lat_mask_q <= '0;
        end else begin
            rd_state <= rd_next;
            rdata_q  <= rdata_nxt;
            rresp_q  <= rresp_nxt;
            if ((rd_state == RD_IDLE) && S_AXI_ARVALID) begin
                araddr_q <= S_AXI_ARADDR;
            end
            if (latch_en) begin
                lat_lo_q   <= fifo_head[31:0];
                lat_mask_q <= fifo_head[64 +: EVENT_COUNT];
            end
        end
    end

    assign S_AXI_ARREADY = (rd_state == RD_IDLE);
    assign S_AXI_RVALID  = (rd_state == RD_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    // ---------------- capture state ----------------
    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            prev_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Edge history tracks the inputs even while capture is disabled, so
            // enabling never manufactures an edge from an already-high input.
            prev_q <= event_in;
            if (clear_now) begin
                overflow_q <= 1'b0;
            end else if (push_req && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef USEC_STAMP_IRQ_EN
    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            irq <= 1'b0;
        end else begin
            irq <= enable_q & ((fifo_count != '0) | overflow_q);
        end
    end
`endif

    assign unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                             eff_data[AXI_DATA_WIDTH-1:2]};

endmodule

// File: tb/tb_usec_event_stamper.sv
// tb/tb_usec_event_stamper.sv - directed-vector bench for usec_event_stamper
module tb_usec_event_stamper;

    logic        AXI_ACLK = 1'b0;
    logic        AXI_ARESETN;
    logic [63:0] usec_counter;
    logic [3:0]  event_in;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
`ifdef USEC_STAMP_IRQ_EN
    logic        irq;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 AXI_ACLK = ~AXI_ACLK;

    usec_event_stamper dut (
        .AXI_ACLK      (AXI_ACLK),
        .AXI_ARESETN   (AXI_ARESETN),
        .usec_counter  (usec_counter),
        .event_in      (event_in),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
`ifdef USEC_STAMP_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge AXI_ACLK);
        #1;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
        logic hs;
        int   n;
        d = '0;
        r = '0;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        n = 0;
        forever begin
            hs = S_AXI_ARREADY;
            step();
            if (hs) break;
            if (++n > 50) begin
                check_vec("ar_timeout", 64'd1, 64'd0);
                break;
            end
        end
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        n = 0;
        forever begin
            hs = S_AXI_RVALID;
            if (hs) begin
                d = S_AXI_RDATA;
                r = S_AXI_RRESP;
            end
            step();
            if (hs) break;
            if (++n > 50) begin
                check_vec("r_timeout", 64'd1, 64'd0);
                break;
            end
        end
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input bit w_lead,
                             input int b_delay, output logic [1:0] r);
        logic hs_a, hs_w;
        int   n;
        S_AXI_WDATA  = d;
        S_AXI_WVALID = 1'b1;
        if (w_lead) begin
            hs_w = S_AXI_WREADY;
            step();
            if (hs_w) S_AXI_WVALID = 1'b0;
            check_vec("w_first_wready_low", 64'(S_AXI_WREADY), 64'd0);
            check_vec("w_first_awready_high", 64'(S_AXI_AWREADY), 64'd1);
        end
        S_AXI_AWADDR  = a;
        S_AXI_AWVALID = 1'b1;
        n = 0;
        while (S_AXI_AWVALID || S_AXI_WVALID) begin
            hs_a = S_AXI_AWVALID & S_AXI_AWREADY;
            hs_w = S_AXI_WVALID & S_AXI_WREADY;
            step();
            if (hs_a) S_AXI_AWVALID = 1'b0;
            if (hs_w) S_AXI_WVALID = 1'b0;
            if (++n > 50) begin
                check_vec("aw_w_timeout", 64'd1, 64'd0);
                S_AXI_AWVALID = 1'b0;
                S_AXI_WVALID  = 1'b0;
            end
        end
        n = 0;
        while (!S_AXI_BVALID && n < 50) begin
            step();
            n++;
        end
        if (!S_AXI_BVALID) check_vec("b_timeout", 64'd1, 64'd0);
        r = S_AXI_BRESP;
        for (int i = 0; i < b_delay; i++) begin
            check_vec("bvalid_held", 64'(S_AXI_BVALID), 64'd1);
            check_vec("bresp_stable", 64'(S_AXI_BRESP), 64'(r));
            step();
        end
        S_AXI_BREADY = 1'b1;
        step();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] ev, input logic [63:0] ts);
        event_in     = ev;
        usec_counter = ts;
        step();
        event_in = 4'd0;
        step();
    endtask

    logic [31:0] d;
    logic [1:0]  r;

    initial begin
        AXI_ARESETN   = 1'b0;
        usec_counter  = '0;
        event_in      = '0;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        repeat (3) step();

        // Reset values
        check_vec("rst_arready", 64'(S_AXI_ARREADY), 64'd1);
        check_vec("rst_awready", 64'(S_AXI_AWREADY), 64'd1);
        check_vec("rst_wready",  64'(S_AXI_WREADY),  64'd1);
        check_vec("rst_rvalid",  64'(S_AXI_RVALID),  64'd0);
        check_vec("rst_bvalid",  64'(S_AXI_BVALID),  64'd0);
        check_vec("rst_rdata",   64'(S_AXI_RDATA),   64'd0);
        check_vec("rst_resp",    64'({S_AXI_RRESP, S_AXI_BRESP}), 64'd0);
        AXI_ARESETN = 1'b1;
        step();
        axi_read(4'h0, d, r);
        check_vec("rst_status", 64'(d), 64'h0);

        // 1: single edge on event 2
        axi_write(4'h0, 32'h2, 1'b0, 0, r);
        check_vec("t1_bresp", 64'(r), 64'd0);
        pulse(4'b0100, 64'h0000_0001_0000_0005);
        axi_read(4'h0, d, r); check_vec("t1_status", 64'(d), 64'h4000_0001);
        axi_read(4'h4, d, r); check_vec("t1_ts_hi", 64'(d), 64'h1);
        check_vec("t1_ts_hi_resp", 64'(r), 64'd0);
        axi_read(4'h8, d, r); check_vec("t1_ts_lo", 64'(d), 64'h5);
        axi_read(4'hC, d, r); check_vec("t1_mask", 64'(d), 64'h4);
        axi_read(4'h0, d, r); check_vec("t1_status_empty", 64'(d), 64'h4000_0000);

        // 2: simultaneous edges share a record
        pulse(4'b1001, 64'h0000_0002_0000_0010);
        axi_read(4'h0, d, r); check_vec("t2_status", 64'(d), 64'h4000_0001);
        axi_read(4'h4, d, r); check_vec("t2_ts_hi", 64'(d), 64'h2);
        axi_read(4'hC, d, r); check_vec("t2_mask", 64'(d), 64'h9);

        // 3: overflow with 17 edges into 16 slots
        for (int i = 0; i < 17; i++) pulse(4'b0010, {32'hA, 32'h100 + 32'(i)});
        axi_read(4'h0, d, r); check_vec("t3_status_full", 64'(d), 64'hC000_0010);
        axi_read(4'h4, d, r); check_vec("t3_first_hi", 64'(d), 64'hA);
        axi_read(4'h8, d, r); check_vec("t3_first_lo", 64'(d), 64'h100);
        axi_read(4'h0, d, r); check_vec("t3_status_15", 64'(d), 64'hC000_000F);
        axi_write(4'h0, 32'h3, 1'b0, 0, r);
        axi_read(4'h0, d, r); check_vec("t3_status_clr", 64'(d), 64'h4000_0000);

        // 4: empty TS_HI, bad read offset, bad write offset
        axi_read(4'h4, d, r); check_vec("t4_empty_data", 64'(d), 64'h0DEC0DE0);
        check_vec("t4_empty_resp", 64'(r), 64'd2);
        axi_read(4'h8, d, r); check_vec("t4_lo_kept", 64'(d), 64'h100);
        axi_read(4'h1, d, r); check_vec("t4_bad_rd", 64'({r, d}), {30'd0, 2'd2, 32'h0DEC0DE0});
        axi_write(4'h8, 32'h0, 1'b0, 0, r);
        check_vec("t4_bad_wr_resp", 64'(r), 64'd2);
        axi_read(4'h0, d, r); check_vec("t4_status_kept", 64'(d), 64'h4000_0000);

        // 5: W before AW, B stalled for 5 cycles
        axi_write(4'h0, 32'h2, 1'b1, 5, r);
        check_vec("t5_bresp", 64'(r), 64'd0);
        check_vec("t5_awready", 64'(S_AXI_AWREADY), 64'd1);
        check_vec("t5_wready",  64'(S_AXI_WREADY),  64'd1);
        check_vec("t5_bvalid",  64'(S_AXI_BVALID),  64'd0);

        // 6: pop concurrent with capture at count 3, then reset mid-read
        for (int j = 0; j < 3; j++) pulse(4'b1000, {32'h20, 32'(j)});
        S_AXI_ARADDR  = 4'h4;
        S_AXI_ARVALID = 1'b1;
        step();
        S_AXI_ARVALID = 1'b0;
        event_in      = 4'b0001;
        usec_counter  = 64'h0000_0030_0000_0000;
        S_AXI_RREADY  = 1'b1;
        step();
        event_in = 4'd0;
        check_vec("t6_rvalid", 64'(S_AXI_RVALID), 64'd1);
        check_vec("t6_pop_hi", 64'(S_AXI_RDATA), 64'h20);
        step();
        S_AXI_RREADY = 1'b0;
        axi_read(4'h0, d, r); check_vec("t6_count_kept", 64'(d), 64'h4000_0003);

        S_AXI_ARADDR  = 4'h0;
        S_AXI_ARVALID = 1'b1;
        step();
        S_AXI_ARVALID = 1'b0;
        AXI_ARESETN   = 1'b0;
        step();
        check_vec("t6_rst_rvalid",  64'(S_AXI_RVALID),  64'd0);
        check_vec("t6_rst_arready", 64'(S_AXI_ARREADY), 64'd1);
        check_vec("t6_rst_rdata",   64'(S_AXI_RDATA),   64'd0);
        AXI_ARESETN = 1'b1;
        step();
        axi_read(4'h0, d, r); check_vec("t6_rst_status", 64'(d), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
